wb_stage: RTL and testbench

//  Write-back stage directly downstream of the memory-access stage. Latches the MEM-stage bundle (MEM/WB

---
 rtl/wb_stage_pkg.sv | 31 +++
 rtl/wb_stage_load_align.sv | 33 +++
 rtl/wb_stage.sv | 101 ++++++++++
 tb/tb_wb_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared bus widths, memory-select encodings and the MEM->WB bundle type
// for the write-back stage.
package wb_stage_pkg;

    localparam int DATA_BUS     = 32;
    localparam int ADDR_BUS     = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int MEM_SEL_BUS  = 4;

    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;

    // Everything the MEM stage hands over, held in the MEM/WB register
    typedef struct packed {
        logic                    read_flag;
        logic                    write_flag;
        logic                    sign_ext_flag;
        logic [MEM_SEL_BUS-1:0]  sel;
        logic [DATA_BUS-1:0]     result;
        logic                    reg_write_en;
        logic [REG_ADDR_BUS-1:0] reg_write_addr;
        logic [ADDR_BUS-1:0]     pc;
    } mem_bundle_t;

    // Widen a loaded byte to a full register, signed or unsigned
    function automatic logic [DATA_BUS-1:0] extend_byte(input logic [7:0] b,
                                                        input logic       sign_ext);
        return sign_ext ? {{(DATA_BUS-8){b[7]}}, b} : {{(DATA_BUS-8){1'b0}}, b};
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte (with extension) or
// passes an aligned word; flags unsupported size/offset combinations.
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [DATA_BUS-1:0]    word,
    input  logic [1:0]             offset,
    input  logic [MEM_SEL_BUS-1:0] sel,
    input  logic                   sign_ext,
    output logic [DATA_BUS-1:0]    data,
    output logic                   ok
);

    logic [7:0] lane [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = word[8*gi +: 8];
    end

    // Select byte lane or full word; anything unsupported yields 0 and ok=0
    always_comb begin
        data = '0;
        ok   = 1'b0;
        if (sel == MEM_SEL_BYTE) begin
            ok   = 1'b1;
            data = extend_byte(lane[offset], sign_ext);
        end else if (sel == MEM_SEL_WORD && offset == 2'b00) begin
            ok   = 1'b1;
            data = word;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load-data hold buffer for
// stalls, and the register-file write port / ID forwarding outputs.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    mem_read_flag_in,
    input  logic                    mem_write_flag_in,
    input  logic                    mem_sign_ext_flag_in,
    input  logic [MEM_SEL_BUS-1:0]  mem_sel_in,
    input  logic [DATA_BUS-1:0]     result_in,
    input  logic                    reg_write_en_in,
    input  logic [REG_ADDR_BUS-1:0] reg_write_addr_in,
    input  logic [ADDR_BUS-1:0]     current_pc_addr_in,
    input  logic [DATA_BUS-1:0]     ram_read_data,
    output logic                    reg_write_en_out,
    output logic [REG_ADDR_BUS-1:0] reg_write_addr_out,
    output logic [DATA_BUS-1:0]     reg_write_data_out,
    output logic [ADDR_BUS-1:0]     current_pc_addr_out
);

    mem_bundle_t         bundle_reg;
    mem_bundle_t         bundle_next;
    logic [DATA_BUS-1:0] load_buf_reg;
    logic                buf_valid_reg;

    logic                is_load;
    logic [DATA_BUS-1:0] align_data;
    logic                align_ok;
    logic [DATA_BUS-1:0] load_data;

    // Gather the incoming MEM bundle
    always_comb begin
        bundle_next                = '0;
        bundle_next.read_flag      = mem_read_flag_in;
        bundle_next.write_flag     = mem_write_flag_in;
        bundle_next.sign_ext_flag  = mem_sign_ext_flag_in;
        bundle_next.sel            = mem_sel_in;
        bundle_next.result         = result_in;
        bundle_next.reg_write_en   = reg_write_en_in;
        bundle_next.reg_write_addr = reg_write_addr_in;
        bundle_next.pc             = current_pc_addr_in;
    end

    // A store never writes load data back, even if the read flag is set
    assign is_load = bundle_reg.read_flag & ~bundle_reg.write_flag;

    wb_stage_load_align u_load_align (
        .word     (ram_read_data),
        .offset   (bundle_reg.result[1:0]),
        .sel      (bundle_reg.sel),
        .sign_ext (bundle_reg.sign_ext_flag),
        .data     (align_data),
        .ok       (align_ok)
    );

    // MEM/WB register: flush inserts a bubble, stall holds, otherwise advance
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bundle_reg <= '0;
        end else if (!stall) begin
            bundle_reg <= bundle_next;
        end
    end

    // Hold buffer: capture aligned RAM data on the first stalled cycle of a load,
    // since the RAM output may change while the pipeline is frozen
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            load_buf_reg  <= '0;
            buf_valid_reg <= 1'b0;
        end else if (stall) begin
            if (is_load && !buf_valid_reg) begin
                load_buf_reg  <= align_data;
                buf_valid_reg <= 1'b1;
            end
        end else begin
            buf_valid_reg <= 1'b0;
        end
    end

    // Buffered copy wins once captured; otherwise align the live RAM word
    assign load_data = buf_valid_reg ? load_buf_reg : align_data;

    // Register-file write port; unsupported loads suppress the write
    always_comb begin
        reg_write_addr_out  = bundle_reg.reg_write_addr;
        current_pc_addr_out = bundle_reg.pc;
        if (is_load) begin
            reg_write_en_out   = bundle_reg.reg_write_en & align_ok;
            reg_write_data_out = load_data;
        end else begin
            reg_write_en_out   = bundle_reg.reg_write_en;
            reg_write_data_out = bundle_reg.result;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage with hand-computed expectations.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        mem_read_flag_in;
    logic        mem_write_flag_in;
    logic        mem_sign_ext_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] result_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] current_pc_addr_in;
    logic [31:0] ram_read_data;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic [31:0] reg_write_data_out;
    logic [31:0] current_pc_addr_out;

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .flush                (flush),
        .mem_read_flag_in     (mem_read_flag_in),
        .mem_write_flag_in    (mem_write_flag_in),
        .mem_sign_ext_flag_in (mem_sign_ext_flag_in),
        .mem_sel_in           (mem_sel_in),
        .result_in            (result_in),
        .reg_write_en_in      (reg_write_en_in),
        .reg_write_addr_in    (reg_write_addr_in),
        .current_pc_addr_in   (current_pc_addr_in),
        .ram_read_data        (ram_read_data),
        .reg_write_en_out     (reg_write_en_out),
        .reg_write_addr_out   (reg_write_addr_out),
        .reg_write_data_out   (reg_write_data_out),
        .current_pc_addr_out  (current_pc_addr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // One clock edge, then settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic rd, input logic wr, input logic sx,
                              input logic [3:0] sel, input logic [31:0] res,
                              input logic en, input logic [4:0] addr,
                              input logic [31:0] pc);
        mem_read_flag_in     = rd;
        mem_write_flag_in    = wr;
        mem_sign_ext_flag_in = sx;
        mem_sel_in           = sel;
        result_in            = res;
        reg_write_en_in      = en;
        reg_write_addr_in    = addr;
        current_pc_addr_in   = pc;
    endtask

    task automatic check_outs(input string tag, input logic en, input logic [4:0] addr,
                              input logic [31:0] data, input logic [31:0] pc);
        check({tag, ".en"},   {31'b0, reg_write_en_out},  {31'b0, en});
        check({tag, ".addr"}, {27'b0, reg_write_addr_out}, {27'b0, addr});
        check({tag, ".data"}, reg_write_data_out, data);
        check({tag, ".pc"},   current_pc_addr_out, pc);
    endtask

    // Byte-load vector: load, then present RAM word and compare data/en
    task automatic byte_load(input string tag, input logic [31:0] addr, input logic sx,
                             input logic [31:0] ram, input logic [31:0] exp);
        set_bundle(1'b1, 1'b0, sx, 4'b0001, addr, 1'b1, 5'd7, 32'h200);
        step();
        ram_read_data = ram;
        #1;
        check({tag, ".en"}, {31'b0, reg_write_en_out}, 32'd1);
        check({tag, ".data"}, reg_write_data_out, exp);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; ram_read_data = 32'h0;
        set_bundle(1'b0, 1'b0, 1'b0, 4'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        check_outs("reset", 1'b0, 5'd0, 32'h0, 32'h0);

        // Seed non-zero inputs while still in reset: outputs must stay zero
        set_bundle(1'b0, 1'b0, 1'b0, 4'b0, 32'hFFFF_0000, 1'b1, 5'd3, 32'h40);
        step();
        check_outs("reset_hold", 1'b0, 5'd0, 32'h0, 32'h0);
        rst = 1'b0;

        // ALU op, one-cycle latency
        set_bundle(1'b0, 1'b0, 1'b0, 4'b0, 32'h0000_1234, 1'b1, 5'd5, 32'h100);
        step();
        check_outs("alu", 1'b1, 5'd5, 32'h0000_1234, 32'h100);

        // Byte loads across lanes and extension modes
        byte_load("lb_s_lane2", 32'h0000_1002, 1'b1, 32'h1280_3456, 32'hFFFF_FF80);
        byte_load("lb_u_lane2", 32'h0000_1002, 1'b0, 32'h1280_3456, 32'h0000_0080);
        byte_load("lb_s_lane3", 32'h0000_1003, 1'b1, 32'h1280_3456, 32'h0000_0012);
        byte_load("lb_s_lane0", 32'h0000_1000, 1'b1, 32'h1280_3456, 32'h0000_0056);
        byte_load("lb_s_lane1", 32'h0000_1001, 1'b1, 32'h0000_F100, 32'hFFFF_FFF1);

        // Word load aligned, then misaligned
        set_bundle(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_1004, 1'b1, 5'd8, 32'h300);
        step();
        ram_read_data = 32'hDEAD_BEEF;
        #1;
        check_outs("lw_align", 1'b1, 5'd8, 32'hDEAD_BEEF, 32'h300);
        set_bundle(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_1006, 1'b1, 5'd8, 32'h304);
        step();
        check("lw_misalign.en", {31'b0, reg_write_en_out}, 32'd0);

        // Unsupported select: no write, zero data
        set_bundle(1'b1, 1'b0, 1'b0, 4'b0011, 32'h0000_1000, 1'b1, 5'd9, 32'h308);
        step();
        check("bad_sel.en", {31'b0, reg_write_en_out}, 32'd0);
        check("bad_sel.data", reg_write_data_out, 32'h0);

        // Store: no write requested, data follows result
        set_bundle(1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_2000, 1'b0, 5'd0, 32'h30C);
        step();
        check("store.en", {31'b0, reg_write_en_out}, 32'd0);
        check("store.data", reg_write_data_out, 32'h0000_2000);

        // Word load followed by a 3-cycle stall with RAM data going away
        set_bundle(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_1008, 1'b1, 5'd10, 32'h400);
        step();
        ram_read_data = 32'hDEAD_BEEF;
        stall = 1'b1;
        #1;
        check_outs("stall_c0", 1'b1, 5'd10, 32'hDEAD_BEEF, 32'h400);
        // Upstream bundle changes during the stall and must be ignored
        set_bundle(1'b0, 1'b0, 1'b0, 4'b0, 32'h0000_9999, 1'b1, 5'd11, 32'h404);
        step();
        ram_read_data = 32'h0;
        #1;
        check_outs("stall_c1", 1'b1, 5'd10, 32'hDEAD_BEEF, 32'h400);
        step();
        check_outs("stall_c2", 1'b1, 5'd10, 32'hDEAD_BEEF, 32'h400);
        step();
        check_outs("stall_c3", 1'b1, 5'd10, 32'hDEAD_BEEF, 32'h400);
        stall = 1'b0;
        set_bundle(1'b0, 1'b0, 1'b0, 4'b0, 32'h0000_0055, 1'b1, 5'd12, 32'h408);
        step();
        check_outs("release", 1'b1, 5'd12, 32'h0000_0055, 32'h408);
        // Buffer cleared: next load takes live RAM data
        set_bundle(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_100C, 1'b1, 5'd13, 32'h40C);
        step();
        ram_read_data = 32'hCAFE_F00D;
        #1;
        check("after_release.data", reg_write_data_out, 32'hCAFE_F00D);

        // Flush and stall together during a load
        set_bundle(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_1010, 1'b1, 5'd14, 32'h500);
        step();
        ram_read_data = 32'h1357_9BDF;
        flush = 1'b1;
        stall = 1'b1;
        step();
        check_outs("flush", 1'b0, 5'd0, 32'h0, 32'h0);
        flush = 1'b0;
        stall = 1'b0;

        // Reset mid-stall with buffer valid; next load must not see the buffer
        set_bundle(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_1014, 1'b1, 5'd9, 32'h600);
        step();
        ram_read_data = 32'h1111_2222;
        stall = 1'b1;
        step();
        ram_read_data = 32'h0;
        #1;
        check("rst_pre.data", reg_write_data_out, 32'h1111_2222);
        rst = 1'b1;
        step();
        check_outs("rst_mid", 1'b0, 5'd0, 32'h0, 32'h0);
        rst = 1'b0;
        stall = 1'b0;
        set_bundle(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_1018, 1'b1, 5'd15, 32'h604);
        step();
        ram_read_data = 32'h3333_4444;
        #1;
        check_outs("post_rst", 1'b1, 5'd15, 32'h3333_4444, 32'h604);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
